// File: rtl/seq_arith_unit_if.sv
// Request/result bundle for seq_arith_unit: operands and opcode in, status and result out.
// The master drives the request side; the slave (the unit) drives busy/done/out_arith/err.
interface seq_arith_unit_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [2:0]           opcode;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   out_arith;
    logic                 err;

    modport master (
        output start, opcode, in_a, in_b,
        input  busy, done, out_arith, err
    );

    modport slave (
        input  start, opcode, in_a, in_b,
        output busy, done, out_arith, err
    );
endinterface

// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: add/sub/inc/dec/and/xor, shift-add MUL, restoring DIV (SEQ_ARITH_DIV_EN).
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV; done pulses when the result lands.
// Backpressure: start is taken only in IDLE/DONE; start during CALC is dropped with no side effect.
module seq_arith_unit #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    seq_arith_unit_if.slave bus
);
    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_next;
    logic               ready, accept, multi, finish;
    logic [CNT_W-1:0]   cnt;
    logic [W2-1:0]      acc;
    logic [WIDTH-1:0]   b_q;
    logic [W2-1:0]      out_q;
    logic               err_q;
    logic [W2-1:0]      sc_res;
    logic               sc_err;
    logic [WIDTH:0]     sum_ab, diff_ab, inc_a, dec_a;
    logic [WIDTH:0]     mul_sum;
    logic [W2-1:0]      iter_next;
    logic               iter_err;
`ifdef SEQ_ARITH_DIV_EN
    logic               div_q;
    logic [WIDTH:0]     div_shift, div_trial;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        ready      = (state != CALC);
        accept     = ready && bus.start;
        multi      = (bus.opcode == OP_MUL);
`ifdef SEQ_ARITH_DIV_EN
        if (bus.opcode == OP_DIV) multi = 1'b1;
`endif
        finish     = (state == CALC) && (cnt == LAST);
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? (multi ? CALC : DONE) : IDLE;
            CALC:       if (finish) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Single-cycle results come straight from the live inputs at the accepting edge.
    assign sum_ab  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign diff_ab = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    assign inc_a   = {1'b0, bus.in_a} + 1'b1;
    assign dec_a   = {1'b0, bus.in_a} - 1'b1;

    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (bus.opcode)
            OP_ADD:  sc_res = W2'(sum_ab);
            OP_SUB:  sc_res = W2'(diff_ab);
            OP_INC:  sc_res = W2'(inc_a);
            OP_DEC:  sc_res = W2'(dec_a);
            OP_AND:  sc_res = W2'(bus.in_a & bus.in_b);
            OP_XOR:  sc_res = W2'(bus.in_a ^ bus.in_b);
`ifdef SEQ_ARITH_DIV_EN
`else
            OP_DIV:  sc_err = 1'b1;
`endif
            default: sc_res = '0;
        endcase
    end

    // acc holds {high, low}: MUL {partial sum, remaining multiplier}, DIV {remainder, quotient}.
    assign mul_sum = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);

`ifdef SEQ_ARITH_DIV_EN
    // With b=0 every trial succeeds, so the quotient fills with ones and in_a shifts into the remainder.
    assign div_shift = acc[W2-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, b_q};

    always_comb begin
        iter_err = 1'b0;
        if (div_q) begin
            iter_err = (b_q == '0);
            if (!div_trial[WIDTH]) iter_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                   iter_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            iter_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end
`else
    assign iter_next = {mul_sum, acc[WIDTH-1:1]};
    assign iter_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= '0;
            b_q   <= '0;
            out_q <= '0;
            err_q <= 1'b0;
`ifdef SEQ_ARITH_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (accept) begin
            cnt <= '0;
            acc <= W2'(bus.in_a);
            b_q <= bus.in_b;
`ifdef SEQ_ARITH_DIV_EN
            div_q <= (bus.opcode == OP_DIV);
`endif
            if (!multi) begin
                out_q <= sc_res;
                err_q <= sc_err;
            end
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            acc <= iter_next;
            if (finish) begin
                out_q <= iter_next;
                err_q <= iter_err;
            end
        end
    end

    assign bus.busy      = (state == CALC);
    assign bus.done      = (state == DONE);
    assign bus.out_arith = out_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit (WIDTH=16); DIV expectations follow SEQ_ARITH_DIV_EN.
module tb_seq_arith_unit;
    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;
    int   done_seen;

    always #5 clk = ~clk;

    seq_arith_unit_if #(.WIDTH(16)) bus ();
    seq_arith_unit #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.in_a   = a;
        bus.in_b   = b;
    endtask

    task automatic check_result(input string tag, input logic [31:0] res, input logic e);
        check({tag, "_done"}, 64'(bus.done), 64'(1'b1));
        check({tag, "_out"},  64'(bus.out_arith), 64'(res));
        check({tag, "_err"},  64'(bus.err), 64'(e));
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = 3'b000;
        bus.in_a   = '0;
        bus.in_b   = '0;
        step();
        step();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_out",  64'(bus.out_arith), 64'(0));
        check("rst_err",  64'(bus.err), 64'(0));
        rst = 1'b0;
        step();

        // ADD completes one cycle after acceptance
        issue(3'b000, 16'h0004, 16'h0007);
        step();
        check_result("add", 32'h0000_000B, 1'b0);
        check("add_busy", 64'(bus.busy), 64'(0));
        bus.start = 1'b0;
        step();
        check("add_done_drop", 64'(bus.done), 64'(0));
        check("add_hold", 64'(bus.out_arith), 64'h0000_000B);

        // back-to-back single-cycle ops, start held through DONE
        issue(3'b001, 16'h0004, 16'h0007);
        step();
        check_result("sub", 32'h0001_FFFD, 1'b0);
        issue(3'b100, 16'hFFFF, 16'h1234);
        step();
        check_result("inc", 32'h0001_0000, 1'b0);
        issue(3'b110, 16'hF0F0, 16'h3C3C);
        step();
        check_result("and", 32'h0000_3030, 1'b0);
        issue(3'b111, 16'hF0F0, 16'h3C3C);
        step();
        check_result("xor", 32'h0000_CCCC, 1'b0);
        issue(3'b101, 16'h0000, 16'h0000);
        step();
        check_result("dec", 32'h0001_FFFF, 1'b0);
        bus.start = 1'b0;
        step();
        check("idle_done", 64'(bus.done), 64'(0));

        // MUL: 16 busy cycles, inputs scrambled and a stray start mid-CALC
        issue(3'b010, 16'h00FF, 16'h0101);
        step();
        bus.start = 1'b0;
        bus.in_a  = 16'hAAAA;
        bus.in_b  = 16'h5555;
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("mul_busy_c%0d", c), 64'(bus.busy), 64'(1));
            check($sformatf("mul_nodone_c%0d", c), 64'(bus.done), 64'(0));
            if (c == 8) begin
                check("mul_out_held", 64'(bus.out_arith), 64'h0001_FFFF);
                issue(3'b000, 16'h0001, 16'h0001);
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        check_result("mul", 32'h0000_FFFF, 1'b0);
        check("mul_busy_end", 64'(bus.busy), 64'(0));
        step();

`ifdef SEQ_ARITH_DIV_EN
        issue(3'b011, 16'd100, 16'd7);
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("div_busy_c%0d", c), 64'(bus.busy), 64'(1));
            step();
        end
        check_result("div", 32'h0002_000E, 1'b0);
        step();
        issue(3'b011, 16'h1234, 16'h0000);
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 16; c++) step();
        check_result("div0", 32'h1234_FFFF, 1'b1);
        step();
`else
        issue(3'b011, 16'd100, 16'd7);
        step();
        bus.start = 1'b0;
        check_result("div_off", 32'h0000_0000, 1'b1);
        check("div_off_busy", 64'(bus.busy), 64'(0));
        step();
`endif
        issue(3'b000, 16'h0001, 16'h0002);
        step();
        bus.start = 1'b0;
        check_result("err_clear", 32'h0000_0003, 1'b0);
        step();

        // reset during CALC cycle 5 of MUL aborts it
        issue(3'b010, 16'h1234, 16'h0002);
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        check("abort_busy_pre", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_out",  64'(bus.out_arith), 64'(0));
        check("abort_err",  64'(bus.err), 64'(0));
        done_seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.done) done_seen++;
            step();
        end
        check("abort_no_done", 64'(done_seen), 64'(0));
        issue(3'b000, 16'h0002, 16'h0003);
        step();
        bus.start = 1'b0;
        check_result("post_rst_add", 32'h0000_0005, 1'b0);
        step();
        check("post_rst_idle", 64'(bus.done), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal 4..32).
REQ-002 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have: start  input  1  request; sampled only while ready.
REQ-005 SHALL have: opcode  input  3  operation select, captured with start.
REQ-006 SHALL have: in_a, in_b  input  WIDTH  unsigned operands, captured with start.
REQ-007 SHALL have: busy  output  1  high while a multi-cycle operation runs.
REQ-008 SHALL have: done  output  1  one-cycle pulse when out_arith/err are valid.
REQ-009 SHALL have: out_arith  output  2*WIDTH  result, held until the next done.
REQ-010 SHALL have: err  output  1  error flag for the last result, updated with done.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE; ready = (state is IDLE or DONE).
REQ-012 SHALL accept start only when ready; start while in CALC SHALL be ignored, no effect on operands or result.
REQ-013 SHALL latch opcode, in_a, in_b on acceptance; later input changes SHALL NOT affect the running operation.
REQ-014 Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 INC a, 101 DEC a, 110 AND, 111 XOR.
REQ-015 Single-cycle ops (all except MUL/DIV): IDLE/DONE -> DONE; done asserts the cycle after acceptance.
REQ-016 MUL/DIV: accept -> CALC for exactly WIDTH cycles (busy=1) -> DONE; done asserts WIDTH+1 cycles after acceptance.
REQ-017 DONE lasts one cycle, then IDLE unless start is accepted in that cycle (back-to-back allowed, no bubble).
REQ-018 ADD/INC: out_arith = zero-extended WIDTH+1-bit sum (carry in bit WIDTH).
REQ-019 SUB/DEC: out_arith bits[WIDTH:0] = {borrow, a-b mod 2^WIDTH}, upper bits zero.
REQ-020 AND/XOR: result in bits[WIDTH-1:0], upper bits zero.
REQ-021 MUL: unsigned shift-add, one partial product per CALC cycle, full 2*WIDTH product.
REQ-022 DIV: unsigned restoring, one quotient bit per CALC cycle; out_arith = {remainder, quotient}.
REQ-023 DIV with in_b=0: quotient all ones, remainder = in_a, err=1; all other results err=0.
REQ-024 out_arith and err SHALL change only in the cycle done asserts.

Reset
REQ-025 rst SHALL force state IDLE, busy=0, done=0, err=0, out_arith=0, clear internal operand/accumulator registers on the next edge.
REQ-026 rst SHALL take priority over start and abort any CALC in progress; no done is produced for the aborted operation.

Configuration
REQ-027 Macro SEQ_ARITH_DIV_EN SHALL compile the divider in; defined: DIV behaves per REQ-016, REQ-022, REQ-023.
REQ-028 Without SEQ_ARITH_DIV_EN: no divider logic; opcode 011 completes as single-cycle, out_arith=0, err=1.

Verification (WIDTH=16, divider enabled unless stated)
REQ-029 ADD a=0x0004 b=0x0007 -> done 1 cycle after accept, out_arith=0x0000000B, err=0.
REQ-030 SUB a=0x0004 b=0x0007 -> out_arith=0x0001FFFD; INC a=0xFFFF -> 0x00010000.
REQ-031 MUL a=0x00FF b=0x0101 -> busy 16 cycles, done at accept+17, out_arith=0x0000FFFF; start pulsed mid-CALC ignored.
REQ-032 DIV a=100 b=7 -> out_arith=0x0002000E at accept+17; DIV a=0x1234 b=0 -> 0x1234FFFF, err=1.
REQ-033 rst asserted at CALC cycle 5 of MUL -> next cycle busy=0, done=0, out_arith=0, no later done; new ADD then completes normally.
REQ-034 SEQ_ARITH_DIV_EN undefined: DIV a=100 b=7 -> done at accept+1, out_arith=0, err=1.
